// File: rtl/isp_tap_select.sv
// ISP output stage: frame-aligned selection of one pipeline tap (or an
// internal colour-bar pattern) onto the registered display outputs.
module isp_tap_select #(
   parameter int DATA_W     = 8,
   parameter int N_TAPS     = 5,
   parameter int MODE_W     = 4,
   parameter int source_h   = 1024,
   parameter int source_v   = 1024,
   parameter int BAR_W      = source_h / 8,
   parameter int RESET_MODE = 0
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [N_TAPS-1:0]        tap_vsync,
   input  logic [N_TAPS-1:0]        tap_hsync,
   input  logic [N_TAPS-1:0]        tap_den,
   input  logic [N_TAPS*DATA_W-1:0] tap_R,
   input  logic [N_TAPS*DATA_W-1:0] tap_G,
   input  logic [N_TAPS*DATA_W-1:0] tap_B,
   input  logic [MODE_W-1:0]        isp_disp_mode,
   output logic                     out_clk,
   output logic                     out_vsync,
   output logic                     out_hsync,
   output logic                     out_den,
   output logic [DATA_W-1:0]        out_data_R,
   output logic [DATA_W-1:0]        out_data_G,
   output logic [DATA_W-1:0]        out_data_B,
   output logic [MODE_W-1:0]        active_mode,
   output logic                     switch_pending
);

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   localparam int SW   = $clog2(N_TAPS + 1);
   localparam int HC_W = (source_h > 1) ? $clog2(source_h) : 1;
   // degenerate geometry falls back to 1-pixel bars
   localparam int BAR_DIV = (BAR_W < 1 || source_v < 1) ? 1 : BAR_W;

   typedef struct packed {
      logic              vs;
      logic              hs;
      logic              de;
      logic [DATA_W-1:0] r;
      logic [DATA_W-1:0] g;
      logic [DATA_W-1:0] b;
   } px_t;

   logic [0:0]        state_q, state_d;
   logic [MODE_W-1:0] active_q, active_d;
   logic [MODE_W-1:0] tgt_q, tgt_d;
   logic [MODE_W-1:0] req_q, req_d;
   logic [N_TAPS-1:0] vs_hist_q, vs_hist_d;
   logic [HC_W-1:0]   h_cnt_q, h_cnt_d;
   px_t               out_q, out_d;

   px_t               src_bus [N_TAPS+1];
   px_t               pat_px;
   logic [N_TAPS:0]   rise_ext;
   logic [31:0]       bar_raw;
   logic [2:0]        bar;
   logic              pending;

   // modes past the last tap map onto the pattern slot
   function automatic logic [SW-1:0] slot(input logic [MODE_W-1:0] m);
      if (int'(m) < N_TAPS) return SW'(m);
      return SW'(N_TAPS);
   endfunction

   // the pattern slot borrows tap 0 frame timing
   assign rise_ext = {tap_vsync[0] & ~vs_hist_q[0],
                      tap_vsync & ~vs_hist_q};
   assign pending  = (req_q != active_q);

   // colour-bar generator driven by the tap 0 pixel counter
   always_comb begin
      h_cnt_d = '0;
      if (tap_den[0]) begin
         if (h_cnt_q == HC_W'(source_h - 1)) h_cnt_d = h_cnt_q;
         else                               h_cnt_d = h_cnt_q + 1'b1;
      end
      bar_raw = 32'(h_cnt_q) / 32'(BAR_DIV);
      bar     = (bar_raw > 32'd7) ? 3'd7 : bar_raw[2:0];
      pat_px    = '0;
      pat_px.vs = tap_vsync[0];
      pat_px.hs = tap_hsync[0];
      pat_px.de = tap_den[0];
      if (tap_den[0]) begin
         pat_px.r = bar[1] ? '0 : '1;
         pat_px.g = bar[2] ? '0 : '1;
         pat_px.b = bar[0] ? '0 : '1;
      end
   end

   // unpack every tap plus the pattern into one indexable source list
   always_comb begin
      for (int k = 0; k < N_TAPS; k++) begin
         src_bus[k].vs = tap_vsync[k];
         src_bus[k].hs = tap_hsync[k];
         src_bus[k].de = tap_den[k];
         src_bus[k].r  = tap_R[k*DATA_W +: DATA_W];
         src_bus[k].g  = tap_G[k*DATA_W +: DATA_W];
         src_bus[k].b  = tap_B[k*DATA_W +: DATA_W];
      end
      src_bus[N_TAPS] = pat_px;
   end

   // frame-boundary switch FSM and next output word
   always_comb begin
      state_d   = state_q;
      active_d  = active_q;
      tgt_d     = tgt_q;
      req_d     = isp_disp_mode;
      vs_hist_d = tap_vsync;
      out_d     = '0;
      case (state_q)
         ST_RUN: begin
            out_d = src_bus[slot(active_q)];
            if (pending && rise_ext[slot(active_q)]) begin
               tgt_d = req_q;
               if (rise_ext[slot(req_q)]) begin
                  active_d = req_q;
                  out_d    = src_bus[slot(req_q)];
               end else begin
                  state_d = ST_WAIT;
                  out_d   = '0;
               end
            end
         end
         ST_WAIT: begin
            if (rise_ext[slot(tgt_q)]) begin
               active_d = tgt_q;
               state_d  = ST_RUN;
               out_d    = src_bus[slot(tgt_q)];
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // state and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_RUN;
         active_q  <= MODE_W'(RESET_MODE);
         tgt_q     <= MODE_W'(RESET_MODE);
         req_q     <= MODE_W'(RESET_MODE);
         vs_hist_q <= '0;
         h_cnt_q   <= '0;
         out_q     <= '0;
      end else begin
         state_q   <= state_d;
         active_q  <= active_d;
         tgt_q     <= tgt_d;
         req_q     <= req_d;
         vs_hist_q <= vs_hist_d;
         h_cnt_q   <= h_cnt_d;
         out_q     <= out_d;
      end
   end

   assign out_clk        = clk;
   assign out_vsync      = out_q.vs;
   assign out_hsync      = out_q.hs;
   assign out_den        = out_q.de;
   assign out_data_R     = out_q.r;
   assign out_data_G     = out_q.g;
   assign out_data_B     = out_q.b;
   assign active_mode    = active_q;
   assign switch_pending = pending;

endmodule

// File: tb/tb_isp_tap_select.sv
// Directed bench for isp_tap_select with a per-cycle output scoreboard
// fed from a frame-level behavioural model of the tap selector.
module tb_isp_tap_select;

   localparam int DW = 8;
   localparam int NT = 5;
   localparam int MW = 4;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [NT-1:0]    tap_vsync, tap_hsync, tap_den;
   logic [NT*DW-1:0] tap_R, tap_G, tap_B;
   logic [MW-1:0]    isp_disp_mode;
   logic             out_clk, out_vsync, out_hsync, out_den;
   logic [DW-1:0]    out_data_R, out_data_G, out_data_B;
   logic [MW-1:0]    active_mode;
   logic             switch_pending;

   isp_tap_select dut (
      .clk(clk), .reset_n(reset_n),
      .tap_vsync(tap_vsync), .tap_hsync(tap_hsync), .tap_den(tap_den),
      .tap_R(tap_R), .tap_G(tap_G), .tap_B(tap_B),
      .isp_disp_mode(isp_disp_mode), .out_clk(out_clk),
      .out_vsync(out_vsync), .out_hsync(out_hsync), .out_den(out_den),
      .out_data_R(out_data_R), .out_data_G(out_data_G),
      .out_data_B(out_data_B), .active_mode(active_mode),
      .switch_pending(switch_pending)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       vs, hs, de;
      logic [7:0] r, g, b;
   } tap_t;

   typedef struct packed {
      tap_t       px;
      logic [3:0] am;
      logic       sp;
   } obs_t;

   int checks = 0;
   int errors = 0;
   int t = 0;
   int line_len = 10;
   int n_lines = 3;
   int off [NT] = '{0, 7, 13, 22, 31};
   int mode_v = 0;
   int drv_p0 = 0;
   tap_t cur [NT];
   logic [NT-1:0] m_vs;
   logic [NT-1:0] last_rise = '0;
   int m_cur, m_tgt, m_req;
   bit m_wait;
   obs_t q [$];

   function automatic tap_t gen(int k, int tt);
      int f, p, ln, x;
      tap_t v;
      f  = line_len * (n_lines + 1);
      p  = (tt + off[k]) % f;
      ln = p / line_len;
      x  = p % line_len;
      v.vs = (p < 2);
      v.hs = (x == 0) && (ln >= 1);
      v.de = (ln >= 1) && (x >= 2) && (x < line_len - 2);
      v.r  = 8'(k * 37 + p * 3 + ln);
      v.g  = v.r + 8'd85;
      v.b  = v.r ^ 8'(k * 16 + 3);
      return v;
   endfunction

   // bar colours straight from the pixel index in the tap 0 line
   function automatic tap_t pat();
      tap_t v;
      int x, bar;
      v   = cur[0];
      v.r = 8'h00;
      v.g = 8'h00;
      v.b = 8'h00;
      x   = (t % (line_len * (n_lines + 1))) % line_len;
      if (v.de) begin
         bar = (x - 2) / 128;
         if (bar > 7) bar = 7;
         v.r = ((bar & 2) == 0) ? 8'hFF : 8'h00;
         v.g = ((bar & 4) == 0) ? 8'hFF : 8'h00;
         v.b = ((bar & 1) == 0) ? 8'hFF : 8'h00;
      end
      return v;
   endfunction

   function automatic tap_t srcv(int m);
      return (m < NT) ? cur[m] : pat();
   endfunction

   function automatic logic srise(int m);
      return last_rise[(m < NT) ? m : 0];
   endfunction

   task automatic model_reset();
      m_cur  = 0;
      m_tgt  = 0;
      m_wait = 0;
      m_req  = 0;
      m_vs   = '0;
      q.delete();
   endtask

   task automatic step();
      obs_t e, o;
      for (int k = 0; k < NT; k++) begin
         cur[k] = gen(k, t);
         tap_vsync[k] = cur[k].vs;
         tap_hsync[k] = cur[k].hs;
         tap_den[k]   = cur[k].de;
         tap_R[k*DW +: DW] = cur[k].r;
         tap_G[k*DW +: DW] = cur[k].g;
         tap_B[k*DW +: DW] = cur[k].b;
      end
      isp_disp_mode = MW'(mode_v);
      drv_p0 = t % (line_len * (n_lines + 1));
      if (reset_n) begin
         for (int k = 0; k < NT; k++)
            last_rise[k] = cur[k].vs & ~m_vs[k];
         e.px = '0;
         if (!m_wait) begin
            e.px = srcv(m_cur);
            if (m_req != m_cur && srise(m_cur)) begin
               m_tgt = m_req;
               if (srise(m_tgt)) begin
                  m_cur = m_tgt;
                  e.px  = srcv(m_cur);
               end else begin
                  m_wait = 1;
                  e.px   = '0;
               end
            end
         end else if (srise(m_tgt)) begin
            m_cur  = m_tgt;
            m_wait = 0;
            e.px   = srcv(m_cur);
         end
         m_req = mode_v;
         m_vs  = tap_vsync;
         e.am  = 4'(m_cur);
         e.sp  = (m_req != m_cur);
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      if (reset_n && q.size() > 0) begin
         e = q.pop_front();
         o.px.vs = out_vsync;
         o.px.hs = out_hsync;
         o.px.de = out_den;
         o.px.r  = out_data_R;
         o.px.g  = out_data_G;
         o.px.b  = out_data_B;
         o.am    = active_mode;
         o.sp    = switch_pending;
         checks++;
         assert (o === e) else begin
            errors++;
            $error("FAIL sb t=%0d obs=%h exp=%h", t, o, e);
         end
      end
      t++;
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_rise(int k);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!last_rise[k] && n < 5000);
      checks++;
      assert (last_rise[k]) else begin
         errors++;
         $error("FAIL wait_rise%0d obs=timeout exp=edge", k);
      end
   endtask

   task automatic go_p0(int p);
      int n;
      n = 0;
      while (drv_p0 != p && n < 5000) begin
         step();
         n++;
      end
      checks++;
      assert (drv_p0 == p) else begin
         errors++;
         $error("FAIL go_p0 obs=%0d exp=%0d", drv_p0, p);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      mode_v  = 2;
      model_reset();
      repeat (3) step();
      chk("rst_vs", 32'(out_vsync), 32'd0);
      chk("rst_den", 32'(out_den), 32'd0);
      chk("rst_rgb", 32'({out_data_R, out_data_G, out_data_B}), 32'd0);
      chk("rst_am", 32'(active_mode), 32'd0);
      chk("rst_sp", 32'(switch_pending), 32'd0);

      reset_n = 1'b1;
      wait_rise(0);
      chk("a_wait_am", 32'(active_mode), 32'd0);
      chk("a_wait_vs", 32'(out_vsync), 32'd0);
      chk("a_wait_sp", 32'(switch_pending), 32'd1);
      wait_rise(2);
      chk("a_sw_am", 32'(active_mode), 32'd2);
      chk("a_sw_sp", 32'(switch_pending), 32'd0);
      chk("a_sw_vs", 32'(out_vsync), 32'd1);

      mode_v = 1;
      wait_rise(2);
      wait_rise(1);
      chk("b_am1", 32'(active_mode), 32'd1);
      repeat (15) step();
      mode_v = 3;
      repeat (2) step();
      chk("b_mid_sp", 32'(switch_pending), 32'd1);
      chk("b_mid_am", 32'(active_mode), 32'd1);
      wait_rise(1);
      chk("b_drop_am", 32'(active_mode), 32'd1);
      chk("b_drop_vs", 32'(out_vsync), 32'd0);
      wait_rise(3);
      chk("b_am3", 32'(active_mode), 32'd3);
      chk("b_vs3", 32'(out_vsync), 32'd1);

      mode_v = 0;
      wait_rise(3);
      wait_rise(0);
      chk("c_am0", 32'(active_mode), 32'd0);
      mode_v = 7;
      wait_rise(0);
      chk("c_am7", 32'(active_mode), 32'd7);
      chk("c_sp", 32'(switch_pending), 32'd0);
      chk("c_vs", 32'(out_vsync), 32'd1);

      mode_v = 0;
      wait_rise(0);
      chk("d_am0", 32'(active_mode), 32'd0);
      chk("d_vs", 32'(out_vsync), 32'd1);
      repeat (5) step();
      mode_v = 4;
      repeat (2) step();
      chk("d_sp_hi", 32'(switch_pending), 32'd1);
      repeat (3) step();
      mode_v = 0;
      repeat (2) step();
      chk("d_sp_lo", 32'(switch_pending), 32'd0);
      wait_rise(0);
      chk("d_keep_am", 32'(active_mode), 32'd0);
      chk("d_keep_vs", 32'(out_vsync), 32'd1);

      mode_v = 3;
      wait_rise(0);
      wait_rise(3);
      chk("e_am3", 32'(active_mode), 32'd3);
      mode_v = 1;
      wait_rise(3);
      chk("e_wait_am", 32'(active_mode), 32'd3);
      chk("e_wait_den", 32'(out_den), 32'd0);
      repeat (2) step();
      reset_n = 1'b0;
      #1;
      chk("e_rst_am", 32'(active_mode), 32'd0);
      chk("e_rst_vs", 32'(out_vsync), 32'd0);
      chk("e_rst_rgb", 32'({out_data_R, out_data_G, out_data_B}), 32'd0);
      model_reset();

      line_len = 1028;
      n_lines  = 1;
      mode_v   = 7;
      repeat (3) step();
      reset_n = 1'b1;
      step();
      wait_rise(0);
      chk("f_am7", 32'(active_mode), 32'd7);
      go_p0(1030);
      chk("f_px0", 32'({out_data_R, out_data_G, out_data_B}), 32'hFFFFFF);
      chk("f_den", 32'(out_den), 32'd1);
      go_p0(1030 + 127);
      chk("f_px127", 32'({out_data_R, out_data_G, out_data_B}), 32'hFFFFFF);
      go_p0(1030 + 128);
      chk("f_px128", 32'({out_data_R, out_data_G, out_data_B}), 32'hFFFF00);
      go_p0(1030 + 255);
      chk("f_px255", 32'({out_data_R, out_data_G, out_data_B}), 32'hFFFF00);
      go_p0(1030 + 384);
      chk("f_px384", 32'({out_data_R, out_data_G, out_data_B}), 32'h00FF00);
      go_p0(1030 + 640);
      chk("f_px640", 32'({out_data_R, out_data_G, out_data_B}), 32'hFF0000);
      go_p0(1030 + 896);
      chk("f_px896", 32'({out_data_R, out_data_G, out_data_B}), 32'h000000);
      go_p0(1030 + 1023);
      chk("f_px1023", 32'({out_data_R, out_data_G, out_data_B}), 32'h000000);
      chk("f_den_last", 32'(out_den), 32'd1);
      step();
      chk("f_blank_den", 32'(out_den), 32'd0);
      chk("f_blank_rgb", 32'({out_data_R, out_data_G, out_data_B}), 32'd0);
      repeat (20) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/isp_tap_select.md
Name: isp_tap_select

Overview:
- Next-generation ISP output stage. Selects one of N_TAPS pipeline taps (RAW, CFA, AWB, CCM, GMA, …) for display.
- Switches between taps only on frame boundaries. A mode change therefore never produces a torn or partial frame at the output.
- Mode values at or above N_TAPS select an internal 8-bar colour-bar test pattern. The pattern uses the timing of tap 0.
- Sits at the end of the ISP chain and drives the display/encoder path.

Parameters:
- DATA_W, 8, bits per colour channel.
- N_TAPS, 5, number of tap inputs; tap 0 is the raw stream, already replicated onto R/G/B by the instantiating level.
- MODE_W, 4, width of mode request and active mode.
- source_h, 1024, active pixels per line.
- source_v, 1024, active lines per frame (informational; not used for counting).
- BAR_W, source_h/8, test-pattern bar width in pixels; must be at least 1.
- RESET_MODE, 0, active mode after reset.

Ports:
- clk  in  1  pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- tap_vsync  in  N_TAPS  per-tap vsync, active high; bit k belongs to tap k.
- tap_hsync  in  N_TAPS  per-tap hsync, active high.
- tap_den  in  N_TAPS  per-tap data enable.
- tap_R  in  N_TAPS*DATA_W  per-tap red; tap k occupies bits [k*DATA_W +: DATA_W].
- tap_G  in  N_TAPS*DATA_W  per-tap green, same packing.
- tap_B  in  N_TAPS*DATA_W  per-tap blue, same packing.
- isp_disp_mode  in  MODE_W  requested mode.
- out_clk  out  1  equal to clk.
- out_vsync  out  1  registered vsync.
- out_hsync  out  1  registered hsync.
- out_den  out  1  registered data enable.
- out_data_R  out  DATA_W  registered red.
- out_data_G  out  DATA_W  registered green.
- out_data_B  out  DATA_W  registered blue.
- active_mode  out  MODE_W  mode currently driving the outputs.
- switch_pending  out  1  high while the requested mode differs from active_mode.

Behaviour:
- Reset (async, reset_n=0):
  - All out_* registers clear to 0.
  - active_mode = RESET_MODE; FSM = RUN.
  - mode_req = RESET_MODE; tgt_mode = RESET_MODE.
  - Per-tap vsync history clears to 0; pattern counter clears to 0.
  - Reset mid-frame: outputs drop to 0 immediately. The first rising vsync after release starts a clean frame.
- Source mapping:
  - src(m) = tap m if m < N_TAPS; otherwise PATTERN.
  - PATTERN takes vsync, hsync and den from tap 0.
  - vs_rise(m) = src(m) vsync is 1 and was 0 on the previous cycle.
- Mode sampling:
  - mode_req <= isp_disp_mode every cycle.
  - switch_pending = (mode_req != active_mode), combinational from registers.
- FSM, RUN state:
  - Outputs are a 1-cycle registered copy of src(active_mode).
  - If switch_pending and vs_rise(active_mode):
    - Latch tgt_mode = mode_req.
    - If vs_rise(tgt_mode) in the same cycle: active_mode <= tgt_mode, stay in RUN. The new source is registered this cycle, so the frame is lossless.
    - Otherwise go to WAIT.
- FSM, WAIT state:
  - out_vsync, out_hsync, out_den and all data registers are driven 0; the old frame is dropped.
  - On vs_rise(tgt_mode): active_mode <= tgt_mode, go to RUN. The new source is registered in that same cycle, so out_vsync rises 1 cycle after the tap vsync edge.
  - Changes to mode_req during WAIT do not alter tgt_mode. They remain pending and are evaluated at the next frame boundary.
  - A request that returns to active_mode before a boundary clears pending; no switch occurs.
- Test pattern:
  - h_cnt counts tap 0 den-high cycles and clears to 0 on any cycle with tap 0 den=0. It saturates at source_h-1.
  - bar = min(h_cnt / BAR_W, 7), using h_cnt before its increment.
  - R = full when bar[1]=0; G = full when bar[2]=0; B = full when bar[0]=0. Full = all ones in DATA_W bits.
  - Resulting bar order: white, yellow, cyan, green, magenta, red, blue, black.
  - Data is forced to 0 when den=0.
- Latency is exactly 1 cycle for all sources. Tap-to-tap latency differences are absorbed by frame-boundary switching.

Test Plan:
- Reset, then mode=2 held: release reset_n with mode 2 held -> active_mode=0 and outputs track tap 0 with 1-cycle delay. At the first tap 0 vsync rise, the switch is evaluated; while tap 2 vsync has not yet risen, outputs stay 0 (WAIT). On tap 2 vsync rise, active_mode=2, switch_pending=0, and out_vsync rises 1 cycle after tap 2 vsync.
- Mid-frame request: mode 1 -> 3 requested mid-frame -> tap 1 data passes unchanged until tap 1 vsync rises. Outputs are 0 until tap 3 vsync rises, then tap 3 is passed through. Exactly one frame is dropped; no partial frame appears.
- Test pattern, DATA_W=8, source_h=1024: mode 7 selected -> pixels 0..127 = FF/FF/FF; pixels 128..255 = FF/FF/00; pixels 896..1023 = 00/00/00; data 0 whenever den=0.
- Simultaneous edges: mode 0 -> 7 -> switch occurs at the tap 0 vsync rise with no WAIT state entered and no frame lost.
- Request reverts: mode 0 -> 4 -> 0 between boundaries -> switch_pending pulses high then returns low; active_mode stays 0 and no frame is dropped.
- Reset during WAIT: assert reset_n=0 while in WAIT -> outputs 0 immediately, active_mode=RESET_MODE after release.
